uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the rv32i_soc serial port, the receive-side counterpart of the SoC's `o_uart_tx` transmitter path. It takes the asynchronous `i_uart_rx` line, oversamples it 16x with a programmable divisor, deframes 8N1 characters LSB first, and buffers received bytes in a small first-word-fall-through FIFO. The core reads bytes through a valid/ready handshake, and sticky error flags report framing errors and overruns.

## Interface
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of 2, ≥2.
- `OVERSAMPLE`, default 16: ticks per bit; fixed at 16, mid-bit is tick 7.
- `clk` input, 1 bit: the single clock; all logic on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `i_uart_rx` input, 1 bit: serial line, asynchronous; idle level is high.
- `i_baud_div` input, 16 bits: tick period minus 1, in clk cycles; one tick every `i_baud_div`+1 clocks. Held static while a frame is in progress.
- `o_rx_data` output, 8 bits: FIFO head byte; valid when `o_rx_valid`=1.
- `o_rx_valid` output, 1 bit: FIFO not empty.
- `i_rx_ready` input, 1 bit: consumer accepts the head byte when `o_rx_valid`=1 and `i_rx_ready`=1.
- `o_rx_count` output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
- `o_frame_err` output, 1 bit: sticky; a stop bit was sampled low.
- `o_overrun` output, 1 bit: sticky; a byte was dropped because the FIFO was full.
- `i_clr_err` input, 1 bit: one-cycle pulse that clears both sticky flags.

## Operation
- **Synchronizer:** two flops on `i_uart_rx`, both reset to 1. All state-machine decisions use the synchronized value `rx_s`.
- **Tick generator:** 16-bit counter.
  - Counts 0 up to `i_baud_div`, then wraps to 0.
  - Asserts `tick` in the cycle the counter equals `i_baud_div`.
  - With `i_baud_div`=0, `tick` is high every cycle.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. A 4-bit tick counter `scnt` and a 3-bit bit index `bidx` run alongside.
  - **IDLE:** on a tick with `rx_s`=0, clear `scnt` and go to START.
  - **START:** at tick where `scnt`=7 (mid start bit):
    - `rx_s`=0: clear `scnt` and `bidx`, go to DATA.
    - `rx_s`=1: glitch; return to IDLE, nothing recorded.
  - **DATA:** every 16 ticks (`scnt`=15), shift `rx_s` into the shift register at bit `bidx` (LSB first). After `bidx`=7, go to STOP.
  - **STOP:** at the 16th tick (mid stop bit):
    - `rx_s`=1: push the shift register into the FIFO, go to IDLE.
    - `rx_s`=0: set `o_frame_err`, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH:** return to IDLE on the first tick with `rx_s`=1. This prevents a break condition from being taken as a new start bit.
- **FIFO:** circular buffer with read/write pointers one bit wider than the address.
  - Push while full, with no pop in the same cycle: drop the byte and set `o_overrun`.
  - Push and pop in the same cycle while full: both happen; no overrun; count unchanged.
  - Push and pop in the same cycle while empty: not possible. Valid is low when empty, so the push alone occurs.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Sticky flags:**
  - Cleared by `i_clr_err`.
  - If a set event occurs in the same cycle as `i_clr_err`, set wins: the flag stays 1.

## Timing
- **Reset values:**
  - FSM in IDLE; synchronizer flops at 1.
  - `o_rx_valid`=0, `o_rx_count`=0, `o_rx_data`=0.
  - `o_frame_err`=0, `o_overrun`=0.
  - Reset mid-frame abandons the partial byte and empties the FIFO. Reception resumes on the next falling edge after reset releases.
- **Input latency:** 2 clk cycles from a pin transition to `rx_s`.
- **Byte latency:** `o_rx_valid` rises, and `o_rx_data` shows the byte, one clock after the stop-bit sample tick.
- **Pop:** the head advances on the clock edge where valid and ready are both 1. The next entry, or valid=0, is visible in the following cycle.
- **Frame length:** a full frame is 160 ticks, i.e. 160×(`i_baud_div`+1) clocks. The start bit is qualified 8 ticks after the falling edge is detected.

## Test plan
- **Basic receive:** `i_baud_div`=0 (bit = 16 clk), send 0xA5 at 16 clk/bit → `o_rx_valid`=1, `o_rx_data`=0xA5, `o_rx_count`=1. Pulse ready → valid=0, count=0.
- **Glitch rejection:** drive the line low for 4 clk, then high → FSM returns to IDLE, no byte, no flags. Then send 0x3C → exactly one byte, 0x3C.
- **Framing error:** send 0x81 with the stop bit low, holding the line low 40 clk → `o_frame_err`=1, count stays 0, no byte while low. Release the line and send 0x55 → 0x55 received. Pulse `i_clr_err` → `o_frame_err`=0.
- **Overrun:** `i_baud_div`=2, ready=0, send 0x01..0x05 → count=4, `o_overrun`=1. Draining yields 0x01, 0x02, 0x03, 0x04.
- **Simultaneous pop on full:** with the FIFO full (0x10..0x13) and ready held 1 on the cycle 0x14 is pushed → no overrun, count stays 4, drain order 0x11, 0x12, 0x13, 0x14.
- **Reset mid-frame:** assert reset after bit 3 of 0xF0, holding the FIFO at 2 bytes → all outputs reach their reset values immediately. After release, 0x7E received correctly as the only byte.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with 16x oversampling, programmable tick
//            divisor and a small first-word-fall-through receive FIFO.
//            Sticky flags report framing errors and FIFO overruns.
// Ports    : clk         - clock, all logic on rising edge
//            reset       - asynchronous active-high reset
//            i_uart_rx   - asynchronous serial line (idle high)
//            i_baud_div  - tick period minus 1, in clk cycles
//            o_rx_data   - FIFO head byte (valid when o_rx_valid)
//            o_rx_valid  - FIFO not empty
//            i_rx_ready  - consumer accepts head byte when valid & ready
//            o_rx_count  - FIFO occupancy
//            o_frame_err - sticky: stop bit sampled low
//            o_overrun   - sticky: byte dropped on full FIFO
//            i_clr_err   - pulse clearing both sticky flags
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_uart_rx,
  input  logic [15:0]                   i_baud_div,
  output logic [7:0]                    o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_count,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  input  logic                          i_clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Last tick of a bit period and the mid-bit tick of the start bit.
  localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SCNT_MID  = 4'(OVERSAMPLE / 2 - 1);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer, reset to the idle (high) line level
  // --------------------------------------------------------------------------
  logic sync1;
  logic rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      rx_s  <= sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Oversampling tick generator
  // --------------------------------------------------------------------------
  logic [15:0] baud_cnt;
  logic        tick;

  // ">=" rather than "==" so that lowering the divisor between frames while
  // the counter sits above the new value wraps at once instead of running
  // the full 16-bit range.
  assign tick = (baud_cnt >= i_baud_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= 16'd0;
    end else if (tick) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Deframing state machine
  // --------------------------------------------------------------------------
  logic [2:0] state;
  logic [3:0] scnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic       stop_sample;
  logic       push;
  logic       stop_bad;

  assign stop_sample = tick && (state == S_STOP) && (scnt == SCNT_LAST);
  assign push        = stop_sample && rx_s;
  assign stop_bad    = stop_sample && !rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      scnt  <= 4'd0;
      bidx  <= 3'd0;
      shreg <= 8'd0;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            scnt  <= 4'd0;
            state <= S_START;
          end
        end
        S_START: begin
          if (scnt == SCNT_MID) begin
            scnt <= 4'd0;
            bidx <= 3'd0;
            // Line back high at mid start bit: treat as a glitch.
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        S_DATA: begin
          if (scnt == SCNT_LAST) begin
            scnt        <= 4'd0;
            shreg[bidx] <= rx_s;
            if (bidx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bidx <= bidx + 3'd1;
            end
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        S_STOP: begin
          if (scnt == SCNT_LAST) begin
            scnt  <= 4'd0;
            // A low stop bit may be a break; wait for the line to recover
            // so the held-low level is not seen as a fresh start bit.
            state <= rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] count;
  logic        full;
  logic        pop;
  logic        wr_en;

  assign count = wptr - rptr;
  assign full  = (count == FULL_COUNT);
  assign pop   = o_rx_valid && i_rx_ready;
  // A simultaneous pop frees the slot, so a push on full still lands.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr              <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  assign o_rx_data  = mem[rptr[AW-1:0]];
  assign o_rx_valid = (count != '0);
  assign o_rx_count = count;

  // --------------------------------------------------------------------------
  // Sticky error flags: a set event outranks a same-cycle clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (stop_bad) begin
        o_frame_err <= 1'b1;
      end else if (i_clr_err) begin
        o_frame_err <= 1'b0;
      end
      if (push && full && !pop) begin
        o_overrun <= 1'b1;
      end else if (i_clr_err) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking testbench for uart_rx. A table of bytes and
//            divisors is received and checked in a loop, followed by
//            hand-written sequences for glitches, framing errors, overrun,
//            push/pop on a full FIFO and reset in the middle of a frame.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic        clk;
  logic        reset;
  logic        i_uart_rx;
  logic [15:0] i_baud_div;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid;
  logic        i_rx_ready;
  logic [2:0]  o_rx_count;
  logic        o_frame_err;
  logic        o_overrun;
  logic        i_clr_err;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx #(
    .FIFO_DEPTH (4),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_uart_rx   (i_uart_rx),
    .i_baud_div  (i_baud_div),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .i_rx_ready  (i_rx_ready),
    .o_rx_count  (o_rx_count),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .i_clr_err   (i_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic [7:0]  exp_data;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one 8N1 frame starting at the current negedge; returns on a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int bit_clks);
    i_uart_rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      i_uart_rx = d[b];
      repeat (bit_clks) @(negedge clk);
    end
    i_uart_rx = stop_bit;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int max_clks);
    int n;
    n = 0;
    while (!o_rx_valid && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!o_rx_valid) begin
      n_fail++;
      $display("FAIL %s: valid still 0 after %0d clks, expected 1", name, max_clks);
    end
  endtask

  task automatic pop_one();
    i_rx_ready = 1'b1;
    @(negedge clk);
    i_rx_ready = 1'b0;
  endtask

  task automatic drain_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(o_rx_valid), 32'd1);
    check({name, "_data"}, 32'(o_rx_data), 32'(exp));
    pop_one();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{div: 16'd0, data: 8'h00, exp_data: 8'h00, exp_count: 3'd1};
    vecs[1] = '{div: 16'd0, data: 8'hFF, exp_data: 8'hFF, exp_count: 3'd1};
    vecs[2] = '{div: 16'd0, data: 8'h96, exp_data: 8'h96, exp_count: 3'd1};
    vecs[3] = '{div: 16'd1, data: 8'h5A, exp_data: 8'h5A, exp_count: 3'd1};
    vecs[4] = '{div: 16'd1, data: 8'h80, exp_data: 8'h80, exp_count: 3'd1};
    vecs[5] = '{div: 16'd3, data: 8'h01, exp_data: 8'h01, exp_count: 3'd1};

    reset      = 1'b1;
    i_uart_rx  = 1'b1;
    i_baud_div = 16'd0;
    i_rx_ready = 1'b0;
    i_clr_err  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", 32'(o_rx_valid), 32'd0);
    check("rst_count", 32'(o_rx_count), 32'd0);
    check("rst_data", 32'(o_rx_data), 32'd0);
    check("rst_frame_err", 32'(o_frame_err), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Basic receive
    send_frame(8'hA5, 1'b1, 16);
    wait_valid("basic_wait", 40);
    check("basic_data", 32'(o_rx_data), 32'h A5);
    check("basic_count", 32'(o_rx_count), 32'd1);
    pop_one();
    check("basic_pop_valid", 32'(o_rx_valid), 32'd0);
    check("basic_pop_count", 32'(o_rx_count), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      i_baud_div = vecs[i].div;
      repeat (8) @(negedge clk);
      send_frame(vecs[i].data, 1'b1, 16 * (int'(vecs[i].div) + 1));
      wait_valid($sformatf("vec%0d_wait", i), 80);
      check($sformatf("vec%0d_data", i), 32'(o_rx_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_count", i), 32'(o_rx_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_ferr", i), 32'(o_frame_err), 32'd0);
      pop_one();
      check($sformatf("vec%0d_empty", i), 32'(o_rx_valid), 32'd0);
    end

    // Glitch rejection
    i_baud_div = 16'd0;
    repeat (8) @(negedge clk);
    i_uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    i_uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_count", 32'(o_rx_count), 32'd0);
    check("glitch_ferr", 32'(o_frame_err), 32'd0);
    check("glitch_ovr", 32'(o_overrun), 32'd0);
    send_frame(8'h3C, 1'b1, 16);
    wait_valid("glitch_rx_wait", 40);
    check("glitch_rx_data", 32'(o_rx_data), 32'h3C);
    check("glitch_rx_count", 32'(o_rx_count), 32'd1);
    pop_one();

    // Framing error with the line held low afterwards
    send_frame(8'h81, 1'b0, 16);
    repeat (40) @(negedge clk);
    check("ferr_flag", 32'(o_frame_err), 32'd1);
    check("ferr_count", 32'(o_rx_count), 32'd0);
    i_uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h55, 1'b1, 16);
    wait_valid("ferr_rx_wait", 40);
    check("ferr_rx_data", 32'(o_rx_data), 32'h55);
    check("ferr_rx_count", 32'(o_rx_count), 32'd1);
    pop_one();
    check("ferr_still_set", 32'(o_frame_err), 32'd1);
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
    check("ferr_cleared", 32'(o_frame_err), 32'd0);

    // Overrun at divisor 2 with the consumer stalled
    i_baud_div = 16'd2;
    repeat (8) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 48);
    end
    repeat (10) @(negedge clk);
    check("ovr_count", 32'(o_rx_count), 32'd4);
    check("ovr_flag", 32'(o_overrun), 32'd1);
    drain_check("ovr_d1", 8'h01);
    drain_check("ovr_d2", 8'h02);
    drain_check("ovr_d3", 8'h03);
    drain_check("ovr_d4", 8'h04);
    check("ovr_empty", 32'(o_rx_valid), 32'd0);
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
    check("ovr_cleared", 32'(o_overrun), 32'd0);

    // Push and pop in the same cycle while full
    i_baud_div = 16'd0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 16);
    end
    repeat (4) @(negedge clk);
    check("full_count", 32'(o_rx_count), 32'd4);
    // Stop-bit sample for a frame started at negedge N0 lands on the
    // rising edge right after negedge N154 (2 sync + 9.5 bit periods).
    fork
      send_frame(8'h14, 1'b1, 16);
      begin
        repeat (154) @(negedge clk);
        i_rx_ready = 1'b1;
        @(negedge clk);
        i_rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("simul_ovr", 32'(o_overrun), 32'd0);
    check("simul_count", 32'(o_rx_count), 32'd4);
    drain_check("simul_d1", 8'h11);
    drain_check("simul_d2", 8'h12);
    drain_check("simul_d3", 8'h13);
    drain_check("simul_d4", 8'h14);
    check("simul_empty", 32'(o_rx_valid), 32'd0);

    // Reset mid-frame with two bytes buffered and a framing error pending
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    send_frame(8'h00, 1'b0, 16);
    repeat (20) @(negedge clk);
    i_uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_pre_count", 32'(o_rx_count), 32'd2);
    check("mid_pre_ferr", 32'(o_frame_err), 32'd1);
    i_uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      i_uart_rx = 1'b0;   // bits 0..3 of 0xF0
      repeat (16) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_rx_valid), 32'd0);
    check("mid_rst_count", 32'(o_rx_count), 32'd0);
    check("mid_rst_data", 32'(o_rx_data), 32'd0);
    check("mid_rst_ferr", 32'(o_frame_err), 32'd0);
    check("mid_rst_ovr", 32'(o_overrun), 32'd0);
    i_uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", 32'(o_rx_count), 32'd0);
    send_frame(8'h7E, 1'b1, 16);
    wait_valid("post_rst_wait", 40);
    check("post_rst_data", 32'(o_rx_data), 32'h7E);
    check("post_rst_count", 32'(o_rx_count), 32'd1);
    pop_one();
    check("post_rst_empty", 32'(o_rx_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
